// File: rtl/cpu6_bus_pkg.sv
// Shared definitions for the CPU6 memory bus arbiter.
//   - bus_state_t : bus cycle sequencer states
//   - ADDR_W      : external address width
//   - DATA_W      : external data width
//   - RDATA_ERR   : read data returned when a cycle times out
package cpu6_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] RDATA_ERR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state and timeout counters for one external bus cycle.
// Ports:
//   clock, reset      : clock and asynchronous active-low reset
//   clear             : zero both counters (asserted in ADDR)
//   enable            : count this cycle (asserted in WAIT)
//   mem_ready         : device ready; low stretches the strobe
//   wait_done         : minimum strobe length has been reached
//   timed_out         : device stayed not-ready for TIMEOUT cycles
module bus_wait_timer #(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic mem_ready,
  output logic wait_done,
  output logic timed_out
);

  localparam logic [3:0] WAIT_MAX    = 4'(WAIT_CYCLES);
  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic [7:0] tout_cnt_reg, tout_cnt_next;

  // "counter has reached WAIT_CYCLES-1", written as cnt+1 >= WAIT_CYCLES
  // in a wider width so it stays valid for WAIT_CYCLES = 1 and 15.
  assign wait_done = ({1'b0, wait_cnt_reg} + 5'd1) >= {1'b0, WAIT_MAX};
  assign timed_out = (tout_cnt_reg == TIMEOUT_MAX);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    tout_cnt_next = tout_cnt_reg;
    if (clear) begin
      wait_cnt_next = '0;
      tout_cnt_next = '0;
    end else if (enable) begin
      if (wait_cnt_reg != WAIT_MAX) begin
        wait_cnt_next = wait_cnt_reg + 4'd1;
      end
      // Only time the device once the minimum strobe is satisfied.
      if (wait_done && !mem_ready && !timed_out) begin
        tout_cnt_next = tout_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
      tout_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      tout_cnt_reg <= tout_cnt_next;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter and cycle sequencer for CPU6.
// Shares one external address/data bus between the CPU port and the DMA
// port with alternating priority, then runs IDLE -> ADDR -> WAIT -> DONE
// for the granted request. All outputs come straight from flops.
// Ports:
//   clock, reset                       : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_ack     : CPU request port, one-cycle ack
//   dma_req/we/addr/wdata, dma_ack     : DMA request port, one-cycle ack
//   rdata                              : data of the last completed read
//   bus_err                            : with the ack when the cycle timed out
//   grant_dma                          : current/last cycle belongs to DMA
//   busy                               : sequencer is not IDLE
//   mem_addr, mem_wdata, mem_rdata     : external address and data
//   mem_oe, mem_we                     : external read / write strobes
//   mem_ready                          : device ready, low adds wait states
module mem_bus_arbiter
  import cpu6_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic              grant_dma,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic              mem_ready
);

  bus_state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              write_reg, write_next;
  logic              grant_dma_reg, grant_dma_next;
  logic              oe_reg, oe_next;
  logic              we_strobe_reg, we_strobe_next;
  logic              cpu_ack_reg, cpu_ack_next;
  logic              dma_ack_reg, dma_ack_next;
  logic              bus_err_reg, bus_err_next;
  logic              busy_reg, busy_next;

  logic take_dma;
  logic timer_clear;
  logic timer_enable;
  logic wait_done;
  logic timed_out;

  bus_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (timer_clear),
    .enable    (timer_enable),
    .mem_ready (mem_ready),
    .wait_done (wait_done),
    .timed_out (timed_out)
  );

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    write_next     = write_reg;
    grant_dma_next = grant_dma_reg;
    oe_next        = 1'b0;
    we_strobe_next = 1'b0;
    cpu_ack_next   = 1'b0;
    dma_ack_next   = 1'b0;
    bus_err_next   = 1'b0;
    take_dma       = 1'b0;
    timer_clear    = 1'b0;
    timer_enable   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cpu_req || dma_req) begin
          // grant_dma_reg holds the previous owner and resets to CPU,
          // so DMA wins the first tie after reset and ties alternate.
          take_dma       = dma_req && (!cpu_req || !grant_dma_reg);
          state_next     = ADDR;
          grant_dma_next = take_dma;
          addr_next      = take_dma ? dma_addr  : cpu_addr;
          wdata_next     = take_dma ? dma_wdata : cpu_wdata;
          write_next     = take_dma ? dma_we    : cpu_we;
        end
      end

      ADDR: begin
        // Address has settled for one cycle; raise the strobe next.
        state_next     = WAIT;
        timer_clear    = 1'b1;
        oe_next        = !write_reg;
        we_strobe_next = write_reg;
      end

      WAIT: begin
        timer_enable = 1'b1;
        if (wait_done && mem_ready) begin
          state_next = DONE;
          if (!write_reg) begin
            rdata_next = mem_rdata;
          end
          cpu_ack_next = !grant_dma_reg;
          dma_ack_next = grant_dma_reg;
        end else if (timed_out) begin
          state_next   = DONE;
          bus_err_next = 1'b1;
          if (!write_reg) begin
            rdata_next = RDATA_ERR;
          end
          cpu_ack_next = !grant_dma_reg;
          dma_ack_next = grant_dma_reg;
        end else begin
          oe_next        = !write_reg;
          we_strobe_next = write_reg;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      write_reg     <= 1'b0;
      grant_dma_reg <= 1'b0;
      oe_reg        <= 1'b0;
      we_strobe_reg <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      bus_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      write_reg     <= write_next;
      grant_dma_reg <= grant_dma_next;
      oe_reg        <= oe_next;
      we_strobe_reg <= we_strobe_next;
      cpu_ack_reg   <= cpu_ack_next;
      dma_ack_reg   <= dma_ack_next;
      bus_err_reg   <= bus_err_next;
      busy_reg      <= busy_next;
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_oe    = oe_reg;
  assign mem_we    = we_strobe_reg;
  assign rdata     = rdata_reg;
  assign cpu_ack   = cpu_ack_reg;
  assign dma_ack   = dma_ack_reg;
  assign bus_err   = bus_err_reg;
  assign grant_dma = grant_dma_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (WAIT_CYCLES = 2, TIMEOUT = 16).
// Cycle numbering: cycle 0 is the IDLE cycle in which a request is first
// presented; outputs are sampled on the falling edge of each cycle.
module tb_mem_bus_arbiter;

  localparam int W  = 2;
  localparam int TO = 16;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic [7:0]  rdata;
  logic        bus_err, grant_dma, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_oe, mem_we, mem_ready;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .WAIT_CYCLES (W),
    .TIMEOUT     (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .grant_dma (grant_dma),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_ready (mem_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mem_rd;
    int          low;       // extra not-ready cycles at the exit point
    int          ack_min;
    int          ack_max;
    logic [7:0]  exp_rdata;
    bit          exp_err;
  } txn_t;

  txn_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {25'd0, mem_addr, mem_wdata, mem_oe, mem_we, cpu_ack, dma_ack,
            rdata, bus_err, grant_dma, busy};
  endfunction

  // One table transaction from an idle bus.
  task automatic run_txn(input int idx, input txn_t t);
    int   ack_cyc, s_cnt, s_first, s_last;
    bit   addr_bad, wdata_bad, grant_bad, kind_bad, other_ack;
    logic [7:0] rd_at_ack;
    logic err_at_ack;
    ack_cyc = -1; s_cnt = 0; s_first = -1; s_last = -1;
    addr_bad = 0; wdata_bad = 0; grant_bad = 0; kind_bad = 0; other_ack = 0;
    rd_at_ack = 8'h00; err_at_ack = 1'b0;

    @(posedge clock); #1;
    mem_rdata = t.mem_rd;
    if (t.dma) begin
      dma_req = 1'b1; dma_we = t.we; dma_addr = t.addr; dma_wdata = t.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
    end

    for (int c = 0; c < 64 && ack_cyc < 0; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      mem_ready = !(t.low > 0 && c >= 1 && c <= W + t.low);
      @(negedge clock);
      if (mem_oe || mem_we) begin
        s_cnt++;
        if (s_first < 0) s_first = c;
        s_last = c;
        if (mem_oe !== !t.we || mem_we !== t.we) kind_bad = 1;
      end
      if (c >= 1) begin
        if (mem_addr !== t.addr) addr_bad = 1;
        if (mem_wdata !== t.wdata) wdata_bad = 1;
        if (grant_dma !== t.dma) grant_bad = 1;
      end
      if ((t.dma ? cpu_ack : dma_ack) === 1'b1) other_ack = 1;
      if ((t.dma ? dma_ack : cpu_ack) === 1'b1) begin
        ack_cyc    = c;
        rd_at_ack  = rdata;
        err_at_ack = bus_err;
        if (t.dma) dma_req = 1'b0; else cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    mem_ready = 1'b1;

    check($sformatf("t%0d_ack_cycle", idx), 64'(ack_cyc >= t.ack_min && ack_cyc <= t.ack_max), 64'd1);
    check($sformatf("t%0d_strobe_window", idx),
          64'(s_first == 2 && s_last == ack_cyc - 1 && s_cnt == ack_cyc - 2), 64'd1);
    check($sformatf("t%0d_strobe_kind", idx), 64'(kind_bad), 64'd0);
    check($sformatf("t%0d_addr_stable", idx), 64'(addr_bad), 64'd0);
    check($sformatf("t%0d_wdata", idx), 64'(wdata_bad), 64'd0);
    check($sformatf("t%0d_grant_dma", idx), 64'(grant_bad), 64'd0);
    check($sformatf("t%0d_other_ack", idx), 64'(other_ack), 64'd0);
    check($sformatf("t%0d_rdata", idx), 64'(rd_at_ack), 64'(t.exp_rdata));
    check($sformatf("t%0d_bus_err", idx), 64'(err_at_ack), 64'(t.exp_err));

    @(posedge clock);
    @(negedge clock);
    check($sformatf("t%0d_ack_pulse", idx), 64'(t.dma ? dma_ack : cpu_ack), 64'd0);
    check($sformatf("t%0d_idle_busy", idx), 64'(busy), 64'd0);
    check($sformatf("t%0d_rdata_hold", idx), 64'(rdata), 64'(t.exp_rdata));

    $display("txn %0d %s %s addr=%h ack_cycle=%0d strobes=%0d rdata=%h bus_err=%0d",
             idx, t.dma ? "dma" : "cpu", t.we ? "write" : "read", t.addr,
             ack_cyc, s_cnt, rd_at_ack, err_at_ack);
  endtask

  initial begin
    int dma_ack_cyc, cpu_ack_cyc, ack_n, ack1, ack2;
    logic g1, g6;
    logic [15:0] addr6;
    logic any_ack;

    tbl[0] = '{dma:1'b0, we:1'b0, addr:16'h1234, wdata:8'h00, mem_rd:8'h5A, low:0,
               ack_min:4, ack_max:4, exp_rdata:8'h5A, exp_err:1'b0};
    tbl[1] = '{dma:1'b1, we:1'b1, addr:16'hBEEF, wdata:8'h3C, mem_rd:8'h99, low:3,
               ack_min:7, ack_max:7, exp_rdata:8'h5A, exp_err:1'b0};
    tbl[2] = '{dma:1'b1, we:1'b0, addr:16'h0001, wdata:8'h10, mem_rd:8'hA5, low:1,
               ack_min:5, ack_max:5, exp_rdata:8'hA5, exp_err:1'b0};
    tbl[3] = '{dma:1'b0, we:1'b1, addr:16'hFFFF, wdata:8'hC7, mem_rd:8'h12, low:0,
               ack_min:4, ack_max:4, exp_rdata:8'hA5, exp_err:1'b0};
    tbl[4] = '{dma:1'b0, we:1'b0, addr:16'h8000, wdata:8'h01, mem_rd:8'h77, low:255,
               ack_min:2 + W + TO - 1, ack_max:2 + W + TO + 1, exp_rdata:8'hFF, exp_err:1'b1};
    tbl[5] = '{dma:1'b1, we:1'b0, addr:16'h0000, wdata:8'h00, mem_rd:8'h00, low:0,
               ack_min:4, ack_max:4, exp_rdata:8'h00, exp_err:1'b0};
    tbl[6] = '{dma:1'b0, we:1'b0, addr:16'h4321, wdata:8'h02, mem_rd:8'hC3, low:2,
               ack_min:6, ack_max:6, exp_rdata:8'hC3, exp_err:1'b0};

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b1;

    // Reset state
    #2;
    check("reset_outputs", all_outputs(), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // Tie after reset: DMA first, CPU 5 cycles later
    @(posedge clock); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC0C0;
    dma_req = 1; dma_we = 0; dma_addr = 16'hD0D0;
    mem_rdata = 8'h11;
    dma_ack_cyc = -1; cpu_ack_cyc = -1; g1 = 1'b0; g6 = 1'b1; addr6 = '0;
    for (int c = 0; c < 40 && cpu_ack_cyc < 0; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      @(negedge clock);
      if (c == 1) g1 = grant_dma;
      if (c == 6) begin g6 = grant_dma; addr6 = mem_addr; end
      if (dma_ack === 1'b1 && dma_ack_cyc < 0) begin dma_ack_cyc = c; dma_req = 0; end
      if (cpu_ack === 1'b1) begin cpu_ack_cyc = c; cpu_req = 0; end
    end
    cpu_req = 0; dma_req = 0;
    check("tie_grant_first", 64'(g1), 64'd1);
    check("tie_dma_ack_cycle", 64'(dma_ack_cyc), 64'd4);
    check("tie_grant_second", 64'(g6), 64'd0);
    check("tie_cpu_addr", 64'(addr6), 64'hC0C0);
    check("tie_ack_spacing", 64'(cpu_ack_cyc - dma_ack_cyc), 64'd5);
    $display("txn tie dma_ack=%0d cpu_ack=%0d", dma_ack_cyc, cpu_ack_cyc);

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(i, tbl[i]);
    end

    // Held request: cpu_req stays high across the first ack
    @(posedge clock); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h5555; mem_rdata = 8'h3E;
    ack_n = 0; ack1 = -1; ack2 = -1;
    for (int c = 0; c < 40 && ack_n < 2; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      @(negedge clock);
      if (cpu_ack === 1'b1) begin
        ack_n++;
        if (ack_n == 1) ack1 = c;
        else begin ack2 = c; cpu_req = 0; end
      end
    end
    cpu_req = 0;
    check("held_ack_count", 64'(ack_n), 64'd2);
    check("held_first_ack", 64'(ack1), 64'd4);
    check("held_ack_spacing", 64'(ack2 - ack1), 64'd5);
    check("held_rdata", 64'(rdata), 64'h3E);
    $display("txn held cpu acks at %0d and %0d", ack1, ack2);
    @(posedge clock); @(posedge clock);

    // Reset in the middle of a read strobe
    @(posedge clock); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h2222; mem_rdata = 8'h66;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check("rst_pre_oe", 64'(mem_oe), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_oe", 64'(mem_oe), 64'd0);
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_all", all_outputs(), 64'd0);
    cpu_req = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    any_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (cpu_ack === 1'b1 || dma_ack === 1'b1) any_ack = 1'b1;
    end
    check("rst_no_ack", 64'(any_ack), 64'd0);
    check("rst_after_all", all_outputs(), 64'd0);
    $display("txn reset_mid_cycle done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences every external memory cycle for the CPU6 processor and shares the single 16-bit address / 8-bit data bus between the microcode-driven CPU port and a DMA port. Sits between CPU6 (which currently drives `addressBus`/`dataBus` directly) and the board-level memory/I/O. It adds:
- alternating-priority arbitration between the two requesters;
- programmable wait states;
- a ready handshake with the external device;
- a timeout that ends any cycle the device never completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: minimum cycles the strobe is asserted. Legal range 1..15.
- `TIMEOUT`, default 64: cycles in WAIT without `mem_ready` before the cycle is aborted. Legal range 16..255.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU requests a bus cycle. Level signal, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read. Held with `cpu_req`.
- `cpu_addr`  in  16  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU.
- `dma_req`, `dma_we`, `dma_addr[15:0]`, `dma_wdata[7:0]`, `dma_ack`: same meanings for the DMA port.
- `rdata`  out  8  read data of the last completed read, from either port.
- `bus_err`  out  1  pulses together with the ack when a cycle timed out.
- `grant_dma`  out  1  the current/last cycle belongs to DMA.
- `busy`  out  1  state is not IDLE.
- `mem_addr`  out  16  external address.
- `mem_wdata`  out  8  external write data.
- `mem_rdata`  in  8  external read data.
- `mem_oe`  out  1  read strobe.
- `mem_we`  out  1  write strobe.
- `mem_ready`  in  1  device ready; low inserts extra wait states.

## Operation
States are IDLE, ADDR, WAIT, DONE.

- **IDLE**
  - If exactly one request is active, grant it.
  - If both are active, grant the port that did not own the previous cycle.
  - After reset, DMA wins the first tie.
  - On a grant: latch address, write data, `we` and the owner; set `grant_dma`; go to ADDR.
- **ADDR**
  - `mem_addr` and `mem_wdata` are driven; both strobes are low.
  - Next state is WAIT; clear the wait and timeout counters.
- **WAIT**
  - Asserts `mem_oe` (read) or `mem_we` (write).
  - The wait counter increments each cycle and saturates at `WAIT_CYCLES`.
  - Exit to DONE when the counter has reached `WAIT_CYCLES - 1` and `mem_ready` is 1.
  - On a normal exit of a read, capture `mem_rdata` into `rdata`.
  - The timeout counter runs only while the counter is satisfied and `mem_ready` is 0.
  - When the timeout counter reaches `TIMEOUT`, exit to DONE with the error flag set; a read loads `rdata` with 8'hFF.
- **DONE**
  - Pulses the owner's ack for one cycle, with `bus_err` if the cycle timed out.
  - Strobes are low; `mem_addr` is held.
  - Returns to IDLE.
- A requester must drop `req` in the cycle after its ack. A `req` still high in IDLE is treated as a new request.
- Requests that arrive while not in IDLE wait; they are never lost.
- Writes leave `rdata` unchanged.

## Timing
- Reset (asynchronous, while `reset` = 0): state goes to IDLE immediately.
  - Every output goes to 0: `mem_addr`, `mem_wdata`, `mem_oe`, `mem_we`, `cpu_ack`, `dma_ack`, `rdata`, `bus_err`, `grant_dma`, `busy`.
  - A reset in the middle of a cycle drops the strobes immediately and issues no ack.
- All outputs are registered.
- With `mem_ready` = 1, a request sampled in IDLE at cycle 0 produces:
  - cycle 1: ADDR;
  - cycles 2 .. 1+`WAIT_CYCLES`: strobe high;
  - cycle 2+`WAIT_CYCLES`: ack high.
  - With `WAIT_CYCLES` = 2, the ack is at cycle 4 and the cycle takes 5 cycles including IDLE.
- Each cycle with `mem_ready` = 0 at the exit point adds one strobe cycle.
- `rdata` is valid in the ack cycle and is held until the next completed read.
- `mem_addr` is stable from ADDR through DONE. Strobes never change in the same cycle as `mem_addr`.
- Back-to-back:
  - A new grant is possible in the IDLE cycle following DONE.
  - The minimum request spacing is `WAIT_CYCLES` + 3 cycles.

## Structure
- Package `cpu6_bus_pkg` holds:
  - the state enum (IDLE, ADDR, WAIT, DONE);
  - the widths `ADDR_W` = 16 and `DATA_W` = 8;
  - the constant `RDATA_ERR` = 8'hFF.
- One sub-module, `bus_wait_timer`: the wait counter plus the timeout counter.
  - Inputs: clear, enable, `mem_ready`.
  - Outputs: `wait_done`, `timed_out`.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Single CPU read:** `WAIT_CYCLES` = 2, `mem_rdata` = 8'h5A, `cpu_addr` = 16'h1234.
  - `mem_oe` high in cycles 2–3.
  - `cpu_ack` pulse at cycle 4.
  - `rdata` = 8'h5A; `mem_addr` = 16'h1234 in cycles 1–4.
- **Tie between ports:** both requests raised together after reset.
  - DMA is served first, then the CPU.
  - `grant_dma` goes 1 then 0.
  - CPU ack arrives exactly 5 cycles after DMA ack.
- **Wait states:** DMA write with `mem_ready` held low for 3 extra cycles.
  - `mem_we` is high for 5 cycles.
  - `dma_ack` at cycle 7.
  - `rdata` unchanged.
- **Timeout:** `mem_ready` stuck at 0, `TIMEOUT` = 16, CPU read.
  - `cpu_ack` and `bus_err` pulse together.
  - `rdata` = 8'hFF.
  - FSM returns to IDLE.
- **Reset in the middle of a cycle:** assert `reset` = 0 during WAIT.
  - `mem_oe` and `busy` fall without waiting for a clock edge.
  - No ack is issued; all outputs read 0.
- **Held request:** `cpu_req` kept high after its ack.
  - A second cycle starts in the IDLE following DONE.
  - Two acks, 5 cycles apart.
